// File: rtl/configure_machine_par.sv
// Minimum-press machine configurator: searches all button subsets, NUM_LANES per clock,
// for the smallest set whose XOR equals the target light pattern.
module configure_machine_par #(
  parameter int unsigned MAX_NUM_LIGHTS  = 10,
  parameter int unsigned MAX_NUM_BUTTONS = 13,
  parameter int unsigned NUM_LANES       = 4,
  // Derived widths; leave at their defaults.
  parameter int unsigned BTN_W = $clog2(MAX_NUM_BUTTONS + 1),
  parameter int unsigned LGT_W = $clog2(MAX_NUM_LIGHTS + 1)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  output logic                                      ready,
  output logic                                      accepted,
  input  logic [LGT_W-1:0]                          num_lights,
  input  logic [BTN_W-1:0]                          num_buttons,
  input  logic [MAX_NUM_LIGHTS-1:0]                 target,
  input  logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0] buttons,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [BTN_W-1:0]                          out_presses,
  output logic [MAX_NUM_BUTTONS-1:0]                out_subset,
  output logic                                      out_found,
  output logic                                      out_err
);

  localparam int unsigned BaseW = MAX_NUM_BUTTONS + 1;

  typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

  state_e                     state_q;
  logic [MAX_NUM_LIGHTS-1:0]  tgt_q;
  logic [MAX_NUM_LIGHTS-1:0]  btn_q [MAX_NUM_BUTTONS];
  logic [BTN_W-1:0]           nbtn_q;
  logic                       err_q;
  logic [BaseW-1:0]           base_q;
  logic [BTN_W-1:0]           best_cnt_q;
  logic [MAX_NUM_BUTTONS-1:0] best_subset_q;
  logic                       found_q;

  logic [MAX_NUM_LIGHTS-1:0]  light_mask;
  logic                       bad_job;
  logic [BaseW-1:0]           limit;
  logic                       last_batch;
  logic [BTN_W-1:0]           best_cnt_d;
  logic [MAX_NUM_BUTTONS-1:0] best_subset_d;
  logic                       found_d;

  always_comb begin
    light_mask = '0;
    for (int i = 0; i < MAX_NUM_LIGHTS; i++) begin
      light_mask[i] = (i < int'(num_lights));
    end
  end

  assign bad_job = (num_buttons > BTN_W'(MAX_NUM_BUTTONS)) ||
                   (num_lights > LGT_W'(MAX_NUM_LIGHTS));

  // Number of subsets of the active buttons: 2**num_buttons.
  assign limit      = {{(BaseW-1){1'b0}}, 1'b1} << nbtn_q;
  assign last_batch = ((base_q + BaseW'(NUM_LANES)) >= limit) || (tgt_q == '0);

  // Lanes are scanned in ascending subset order, so a strict "<" keeps the lowest s on ties.
  always_comb begin
    logic [BaseW-1:0]          s;
    logic [MAX_NUM_LIGHTS-1:0] x;
    logic [BTN_W-1:0]          cnt;
    best_cnt_d    = best_cnt_q;
    best_subset_d = best_subset_q;
    found_d       = found_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      s   = base_q + BaseW'(k);
      x   = '0;
      cnt = '0;
      for (int i = 0; i < MAX_NUM_BUTTONS; i++) begin
        if (s[i]) begin
          x   = x ^ btn_q[i];
          cnt = cnt + BTN_W'(1);
        end
      end
      if ((s < limit) && (x == tgt_q) && (cnt < best_cnt_d)) begin
        best_cnt_d    = cnt;
        best_subset_d = s[MAX_NUM_BUTTONS-1:0];
        found_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ready         <= 1'b1;
      accepted      <= 1'b0;
      out_valid     <= 1'b0;
      out_presses   <= '0;
      out_subset    <= '0;
      out_found     <= 1'b0;
      out_err       <= 1'b0;
      tgt_q         <= '0;
      nbtn_q        <= '0;
      err_q         <= 1'b0;
      base_q        <= '0;
      best_cnt_q    <= '1;
      best_subset_q <= '0;
      found_q       <= 1'b0;
      for (int i = 0; i < MAX_NUM_BUTTONS; i++) begin
        btn_q[i] <= '0;
      end
    end else begin
      accepted <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            accepted      <= 1'b1;
            ready         <= 1'b0;
            tgt_q         <= target & light_mask;
            for (int i = 0; i < MAX_NUM_BUTTONS; i++) begin
              btn_q[i] <= buttons[i*MAX_NUM_LIGHTS +: MAX_NUM_LIGHTS] & light_mask;
            end
            nbtn_q        <= num_buttons;
            err_q         <= bad_job;
            base_q        <= '0;
            best_cnt_q    <= '1;
            best_subset_q <= '0;
            found_q       <= 1'b0;
            state_q       <= bad_job ? StDone : StSearch;
          end
        end
        StSearch: begin
          base_q        <= base_q + BaseW'(NUM_LANES);
          best_cnt_q    <= best_cnt_d;
          best_subset_q <= best_subset_d;
          found_q       <= found_d;
          if (last_batch) state_q <= StDone;
        end
        StDone: begin
          if (!out_valid) begin
            out_valid   <= 1'b1;
            out_presses <= found_q ? best_cnt_q : '0;
            out_subset  <= found_q ? best_subset_q : '0;
            out_found   <= found_q;
            out_err     <= err_q;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            ready     <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_configure_machine_par.sv
// Bench for configure_machine_par: brute-force subset model plus directed scenarios.
module tb_configure_machine_par;
  localparam int L  = 10;
  localparam int B  = 13;
  localparam int N  = 4;
  localparam int BW = 4;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            rst, start, ready, accepted, out_valid, out_ready, out_found, out_err;
  logic [LW-1:0]   num_lights;
  logic [BW-1:0]   num_buttons;
  logic [L-1:0]    target;
  logic [B*L-1:0]  buttons;
  logic [BW-1:0]   out_presses;
  logic [B-1:0]    out_subset;

  int checks = 0;
  int errors = 0;

  // Model expectations for the job in flight.
  bit exp_live = 0;
  int exp_presses, exp_subset, exp_lat;
  bit exp_found, exp_err;
  // Values captured when out_valid rises, for literal checks.
  int got_presses, got_subset, got_found, got_err, got_lat;

  configure_machine_par dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .accepted(accepted),
    .num_lights(num_lights), .num_buttons(num_buttons), .target(target), .buttons(buttons),
    .out_valid(out_valid), .out_ready(out_ready), .out_presses(out_presses),
    .out_subset(out_subset), .out_found(out_found), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  function automatic logic [B*L-1:0] pk(input int b0 = 0, input int b1 = 0, input int b2 = 0,
                                        input int b3 = 0, input int b4 = 0, input int b5 = 0);
    logic [B*L-1:0] v;
    v = '0;
    v[0*L +: L] = L'(b0);
    v[1*L +: L] = L'(b1);
    v[2*L +: L] = L'(b2);
    v[3*L +: L] = L'(b3);
    v[4*L +: L] = L'(b4);
    v[5*L +: L] = L'(b5);
    return v;
  endfunction

  // Exhaustive search in ascending subset order; latency counted from the start cycle.
  function automatic void model(input int nl, input int nb, input int t,
                                input logic [B*L-1:0] btn, output int p, output int sub,
                                output bit f, output bit e, output int lat);
    int m, tm, x, best;
    e = (nb > B) || (nl > L);
    p = 0; sub = 0; f = 0;
    if (e) begin
      lat = 2;
      return;
    end
    m = (1 << nl) - 1;
    tm = t & m;
    best = B + 1;
    for (int s = 0; s < (1 << nb); s++) begin
      x = 0;
      for (int i = 0; i < nb; i++) if (s[i]) x = x ^ (int'(btn[i*L +: L]) & m);
      if (x == tm && $countones(s) < best) begin
        best = $countones(s);
        sub = s;
        f = 1;
      end
    end
    if (f) p = best;
    lat = 2 + ((tm == 0) ? 1 : (((1 << nb) + N - 1) / N));
  endfunction

  // Single compare process against the model.
  always @(negedge clk) begin
    if (!rst && exp_live && out_valid) begin
      check("out_presses", int'(out_presses), exp_presses);
      check("out_subset", int'(out_subset), exp_subset);
      check("out_found", int'(out_found), int'(exp_found));
      check("out_err", int'(out_err), int'(exp_err));
      check("ready_in_done", int'(ready), 0);
    end else if (!rst && !exp_live) begin
      check("no_spurious_valid", int'(out_valid), 0);
    end
  end

  task automatic launch(input int nl, input int nb, input int t, input logic [B*L-1:0] btn);
    model(nl, nb, t, btn, exp_presses, exp_subset, exp_found, exp_err, exp_lat);
    @(negedge clk);
    num_lights = LW'(nl); num_buttons = BW'(nb); target = L'(t); buttons = btn;
    start = 1'b1;
    exp_live = 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    num_lights = '0; num_buttons = '0; target = '0; buttons = '1;
    check("accepted_pulse", int'(accepted), 1);
    check("ready_low_busy", int'(ready), 0);
  endtask

  task automatic run_job(input int nl, input int nb, input int t, input logic [B*L-1:0] btn,
                         input int hold, input bit illegal_start);
    int cnt;
    launch(nl, nb, t, btn);
    cnt = 1;
    while (!out_valid && cnt < 5000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("out_valid_latency", cnt, exp_lat);
    got_lat = cnt;
    got_presses = int'(out_presses); got_subset = int'(out_subset);
    got_found = int'(out_found); got_err = int'(out_err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      start = (illegal_start && i == 3);
      @(posedge clk);
      #1;
      check("no_accept_in_done", int'(accepted), 0);
      check("valid_held", int'(out_valid), 1);
    end
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_live = 0;
    out_ready = 1'b0;
    check("idle_after_handshake", int'(ready), 1);
    check("valid_dropped", int'(out_valid), 0);
  endtask

  initial begin
    logic [B*L-1:0] rb;
    int rt;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    num_lights = '0; num_buttons = '0; target = '0; buttons = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(ready), 1);
    check("rst_accepted", int'(accepted), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_presses", int'(out_presses), 0);
    check("rst_out_subset", int'(out_subset), 0);
    check("rst_out_found", int'(out_found), 0);
    check("rst_out_err", int'(out_err), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: example machine
    run_job(4, 6, 'h6, pk('h8, 'hA, 'h4, 'hC, 'h5, 'h3), 0, 0);
    check("t1_presses", got_presses, 2);
    check("t1_subset", got_subset, 'h0A);
    check("t1_found", got_found, 1);
    check("t1_latency", got_lat, 18);

    // 2: zero target exits after one batch
    run_job(4, 6, 'h0, pk('h8, 'hA, 'h4, 'hC, 'h5, 'h3), 0, 0);
    check("t2_presses", got_presses, 0);
    check("t2_subset", got_subset, 0);
    check("t2_found", got_found, 1);
    check("t2_latency", got_lat, 3);

    // 3: no solution
    run_job(3, 2, 'h4, pk('h1, 'h1), 0, 0);
    check("t3_found", got_found, 0);
    check("t3_presses", got_presses, 0);
    check("t3_subset", got_subset, 0);

    // 4: light masking
    run_job(2, 1, 'h7, pk('h3), 0, 0);
    check("t4_presses", got_presses, 1);
    check("t4_subset", got_subset, 'h1);

    // 5: back-pressure with an illegal start in the window
    run_job(4, 6, 'h6, pk('h8, 'hA, 'h4, 'hC, 'h5, 'h3), 10, 1);

    // num_buttons = 0
    run_job(4, 0, 'h5, pk('h5), 0, 0);
    check("nb0_found", got_found, 0);
    run_job(4, 0, 'h0, pk('h5), 0, 0);
    check("nb0_zero_found", got_found, 1);

    // 6: reset during search, then a clean job
    launch(4, 6, 'h6, pk('h8, 'hA, 'h4, 'hC, 'h5, 'h3));
    repeat (5) @(posedge clk);
    @(negedge clk);
    exp_live = 0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t6_valid_after_rst", int'(out_valid), 0);
    check("t6_ready_after_rst", int'(ready), 1);
    run_job(4, 6, 'h6, pk('h8, 'hA, 'h4, 'hC, 'h5, 'h3), 0, 0);
    check("t6_presses", got_presses, 2);
    check("t6_subset", got_subset, 'h0A);

    // 7: error jobs
    run_job(4, B + 1, 'h6, pk('h8), 0, 0);
    check("t7_err", got_err, 1);
    check("t7_found", got_found, 0);
    run_job(L + 1, 3, 'h6, pk('h8), 0, 0);
    check("t7b_err", got_err, 1);

    // Full-width search with random buttons and a reachable target
    rb = '0;
    for (int i = 0; i < B; i++) rb[i*L +: L] = L'($urandom);
    rt = int'(rb[2*L +: L] ^ rb[7*L +: L] ^ rb[11*L +: L]);
    run_job(L, B, rt, rb, 2, 0);
    check("full_found", got_found, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
